// File: rtl/uart_report_sequencer.sv
// uart_report_sequencer: turns each DHT11 sample into an 11-byte "H:hh T:tt\r\n" report sent through uart_tx.
// Ports: clk, rst (async, active-high); sample_valid/humidity/temperature from the sampler;
// tx_busy in and tx_start/tx_data out to uart_tx; report_busy, overrun and timeout_err status.
module uart_report_sequencer #(
  parameter int BUSY_TIMEOUT = 64,
  parameter int REPORT_LEN = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       report_busy,
  output logic       overrun,
  output logic       timeout_err
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BUSY_TIMEOUT - 1);
  localparam logic [3:0] LAST_IDX = 4'(REPORT_LEN - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] idx, h_tens, h_ones, t_tens, t_ones;
  logic [7:0] pend_h, pend_t, src_h, src_t, sel_byte;
  logic pend_full;
  function automatic logic [3:0] tens(input logic [7:0] v);
    logic [7:0] c;
    c = (v > 8'd99 ? 8'd99 : v) / 8'd10;
    return c[3:0];
  endfunction
  function automatic logic [3:0] ones(input logic [7:0] v);
    logic [7:0] c;
    c = (v > 8'd99 ? 8'd99 : v) % 8'd10;
    return c[3:0];
  endfunction
  // A waiting sample always goes ahead of one arriving in the same cycle.
  assign src_h = pend_full ? pend_h : humidity;
  assign src_t = pend_full ? pend_t : temperature;
  assign report_busy = state != IDLE;
  always_comb begin
    sel_byte = 8'h0A;
    case (idx)
      4'd0: sel_byte = 8'h48;
      4'd1, 4'd6: sel_byte = 8'h3A;
      4'd2: sel_byte = {4'h3, h_tens};
      4'd3: sel_byte = {4'h3, h_ones};
      4'd4: sel_byte = 8'h20;
      4'd5: sel_byte = 8'h54;
      4'd7: sel_byte = {4'h3, t_tens};
      4'd8: sel_byte = {4'h3, t_ones};
      4'd9: sel_byte = 8'h0D;
      default: sel_byte = 8'h0A;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      {h_tens, h_ones, t_tens, t_ones} <= '0;
      {pend_h, pend_t, pend_full} <= '0;
      {tx_start, tx_data, overrun, timeout_err} <= '0;
    end else begin
      tx_start <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      // A sample lands in the slot while busy, or in IDLE when the slot is being drained this cycle.
      if (sample_valid && (state != IDLE || pend_full)) begin
        pend_h <= humidity;
        pend_t <= temperature;
        pend_full <= 1'b1;
        overrun <= pend_full && state != IDLE;
      end else if (state == IDLE && pend_full) begin
        pend_full <= 1'b0;
      end
      case (state)
        IDLE: if (sample_valid || pend_full) begin
          h_tens <= tens(src_h);
          h_ones <= ones(src_h);
          t_tens <= tens(src_t);
          t_ones <= ones(src_t);
          state <= LOAD;
        end
        LOAD: begin
          tx_data <= sel_byte;
          state <= START;
        end
        START: if (!tx_busy) begin
          tx_start <= 1'b1;
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (tx_busy) begin
          state <= WAIT_DONE;
        end else if (cnt == LAST_CNT) begin
          timeout_err <= 1'b1;
          idx <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        WAIT_DONE: if (!tx_busy) begin
          idx <= idx == LAST_IDX ? 4'd0 : idx + 4'd1;
          state <= idx == LAST_IDX ? IDLE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_report_sequencer.sv
// tb_uart_report_sequencer: scoreboard bench for uart_report_sequencer with a simple uart_tx busy model.
module tb_uart_report_sequencer;
  localparam int BT = 64;
  logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0;
  logic [7:0] humidity = '0, temperature = '0;
  logic tx_busy, tx_start, report_busy, overrun, timeout_err;
  logic [7:0] tx_data;
  logic model_en = 1'b1, force_busy = 1'b0;
  int bcnt = 0;
  int checks = 0, fails = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, ovr_cnt = 0, to_cnt = 0, to_cyc = -1000;
  logic prev_start = 1'b0, prev_rb = 1'b0, in_tx = 1'b0;
  logic [7:0] cur_byte = '0;
  logic [7:0] exp_q[$];

  uart_report_sequencer #(.BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .humidity(humidity),
    .temperature(temperature), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .report_busy(report_busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises the cycle after tx_start and stays high 20 cycles.
  always @(posedge clk or posedge rst)
    if (rst) bcnt <= 0;
    else if (tx_start && model_en) bcnt <= 20;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  assign tx_busy = force_busy || bcnt != 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tx_start pops the next expected byte.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_start) begin
        int e;
        e = exp_q.size() != 0 ? int'(exp_q.pop_front()) : -1;
        chk("start_pulse_width", int'(prev_start), 0);
        chk("tx_byte", int'(tx_data), e);
        start_cnt++;
        start_cyc = cyc;
        cur_byte = tx_data;
        in_tx = 1'b1;
      end else if (in_tx) begin
        if (tx_busy) chk("tx_data_stable", int'(tx_data), int'(cur_byte));
        else in_tx = 1'b0;
      end
      if (prev_rb && !report_busy) chk("busy_low_at_report_end", int'(tx_busy), 0);
      if (overrun) ovr_cnt++;
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end else begin
      in_tx = 1'b0;
    end
    prev_start = tx_start;
    prev_rb = report_busy;
  end

  task automatic send(input logic [7:0] h, input logic [7:0] t);
    @(negedge clk);
    humidity = h;
    temperature = t;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic push_report(input logic [7:0] h1, input logic [7:0] h0,
                             input logic [7:0] t1, input logic [7:0] t0);
    exp_q.push_back(8'h48); exp_q.push_back(8'h3A); exp_q.push_back(h1); exp_q.push_back(h0);
    exp_q.push_back(8'h20); exp_q.push_back(8'h54); exp_q.push_back(8'h3A); exp_q.push_back(t1);
    exp_q.push_back(t0); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic wait_quiet();
    int q = 0;
    for (int i = 0; i < 3000 && q < 3; i++) begin
      @(negedge clk);
      q = (exp_q.size() == 0 && !report_busy) ? q + 1 : 0;
    end
    chk("drain_done", q, 3);
  endtask

  initial begin
    int s0;
    #12;
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_report_busy", int'(report_busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    push_report(8'h34, 8'h35, 8'h32, 8'h33);
    send(8'd45, 8'd23);
    wait_quiet();
    chk("report1_starts", start_cnt - s0, 11);
    push_report(8'h39, 8'h39, 8'h30, 8'h30);
    send(8'd150, 8'd0);
    wait_quiet();
    s0 = start_cnt;
    push_report(8'h31, 8'h31, 8'h32, 8'h32);
    send(8'd11, 8'd22);
    repeat (30) @(negedge clk);
    send(8'd33, 8'd44);
    repeat (30) @(negedge clk);
    chk("no_overrun_on_b", ovr_cnt, 0);
    push_report(8'h35, 8'h35, 8'h36, 8'h36);
    send(8'd55, 8'd66);
    wait_quiet();
    chk("overrun_count", ovr_cnt, 1);
    chk("overrun_starts", start_cnt - s0, 22);
    force_busy = 1'b1;
    @(negedge clk);
    s0 = start_cnt;
    push_report(8'h30, 8'h37, 8'h30, 8'h38);
    send(8'd7, 8'd8);
    repeat (10) @(negedge clk);
    chk("start_withheld", start_cnt - s0, 0);
    chk("busy_while_held", int'(report_busy), 1);
    force_busy = 1'b0;
    wait_quiet();
    chk("held_report_starts", start_cnt - s0, 11);
    model_en = 1'b0;
    exp_q.push_back(8'h48);
    send(8'd12, 8'd34);
    for (int i = 0; i < 200 && !timeout_err; i++) @(negedge clk);
    @(negedge clk);
    chk("timeout_latency", to_cyc - start_cyc, BT);
    chk("timeout_count", to_cnt, 1);
    chk("idle_after_timeout", int'(report_busy), 0);
    model_en = 1'b1;
    push_report(8'h30, 8'h39, 8'h39, 8'h39);
    send(8'd9, 8'd99);
    wait_quiet();
    s0 = start_cnt;
    push_report(8'h35, 8'h35, 8'h36, 8'h36);
    send(8'd55, 8'd66);
    for (int i = 0; i < 500 && start_cnt < s0 + 5; i++) @(negedge clk);
    chk("reached_byte5", start_cnt - s0, 5);
    #7;
    rst = 1'b1;
    #1;
    chk("midrst_tx_start", int'(tx_start), 0);
    chk("midrst_tx_data", int'(tx_data), 0);
    chk("midrst_report_busy", int'(report_busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_report(8'h30, 8'h31, 8'h30, 8'h32);
    send(8'd1, 8'd2);
    wait_quiet();
    chk("final_overrun_count", ovr_cnt, 1);
    chk("final_timeout_count", to_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
